// File: rtl/e203_exu_bjp_flush_ctrl_pkg.sv
// Shared types and constants for the BJP flush controller.
package e203_exu_bjp_flush_ctrl_pkg;

    // Controller state encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Instruction lengths in bytes
    localparam int unsigned INSN_LEN_32 = 4;
    localparam int unsigned INSN_LEN_16 = 2;

    // Redirect target source
    typedef enum logic [2:0] {
        TGT_MEPC = 3'd0,
        TGT_DPC  = 3'd1,
        TGT_SEQ  = 3'd2,
        TGT_JALR = 3'd3,
        TGT_BR   = 3'd4
    } tgt_sel_e;

    // Priority pick of the redirect source: mret > dret > fence.i > jalr > resolved direction
    function automatic tgt_sel_e tgt_sel(
        input logic mret,
        input logic dret,
        input logic fencei,
        input logic jalr,
        input logic rslv
    );
        if (mret)        return TGT_MEPC;
        else if (dret)   return TGT_DPC;
        else if (fencei) return TGT_SEQ;
        else if (jalr)   return TGT_JALR;
        else if (rslv)   return TGT_BR;
        else             return TGT_SEQ;
    endfunction

endpackage

// File: rtl/e203_exu_bjp_tgt_calc.sv
// Combinational redirect target mux/adder; all sums wrap at PC width.
module e203_exu_bjp_tgt_calc
    import e203_exu_bjp_flush_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_SIZE = 32
) (
    input  tgt_sel_e             sel,
    input  logic                 rv32,
    input  logic [PC_SIZE-1:0]   pc,
    input  logic [XLEN-1:0]      rs1,
    input  logic [XLEN-1:0]      imm,
    input  logic [PC_SIZE-1:0]   csr_mepc,
    input  logic [PC_SIZE-1:0]   csr_dpc,
    output logic [PC_SIZE-1:0]   tgt
);

    logic [PC_SIZE-1:0] len;
    logic [XLEN-1:0]    jalr_sum;

    // Select the target for the chosen redirect source
    always_comb begin
        len      = rv32 ? PC_SIZE'(INSN_LEN_32) : PC_SIZE'(INSN_LEN_16);
        jalr_sum = rs1 + imm;
        tgt      = pc + len;
        case (sel)
            TGT_MEPC: tgt = csr_mepc;
            TGT_DPC:  tgt = csr_dpc;
            TGT_SEQ:  tgt = pc + len;
            TGT_JALR: tgt = PC_SIZE'(jalr_sum) & ~PC_SIZE'(1);
            TGT_BR:   tgt = pc + PC_SIZE'(imm);
            default:  tgt = pc + len;
        endcase
    end

endmodule

// File: rtl/e203_exu_bjp_flush_ctrl.sv
// BJP commit consumer: detects mispredicts/serializing ops, raises a held
// redirect request to the IFU, and keeps branch/mispredict statistics.
module e203_exu_bjp_flush_ctrl
    import e203_exu_bjp_flush_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_SIZE = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmt_i_valid,
    output logic                 cmt_i_ready,
    input  logic                 cmt_i_bjp,
    input  logic                 cmt_i_jalr,
    input  logic                 cmt_i_mret,
    input  logic                 cmt_i_dret,
    input  logic                 cmt_i_fencei,
    input  logic                 cmt_i_prdt,
    input  logic                 cmt_i_rslv,
    input  logic                 cmt_i_rv32,
    input  logic [PC_SIZE-1:0]   cmt_i_pc,
    input  logic [XLEN-1:0]      cmt_i_rs1,
    input  logic [XLEN-1:0]      cmt_i_imm,
    input  logic [PC_SIZE-1:0]   csr_mepc,
    input  logic [PC_SIZE-1:0]   csr_dpc,
    input  logic                 excp_flush,
    output logic                 flush_req,
    output logic [PC_SIZE-1:0]   flush_pc,
    input  logic                 flush_ack,
    output logic [CNT_W-1:0]     bjp_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);

    state_e             state_q, state_d;
    logic               flush_req_q, flush_req_d;
    logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
    logic [CNT_W-1:0]   bjp_cnt_q, bjp_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic               accept;
    logic               mispred;
    logic               need_flush;
    tgt_sel_e           sel;
    logic [PC_SIZE-1:0] tgt;

    // Decode the commit entry: handshake, mispredict and redirect source
    always_comb begin
        cmt_i_ready = (state_q == ST_IDLE) & ~excp_flush;
        accept      = cmt_i_valid & cmt_i_ready;
        mispred     = cmt_i_bjp & ~cmt_i_jalr & (cmt_i_prdt ^ cmt_i_rslv);
        need_flush  = cmt_i_mret | cmt_i_dret | cmt_i_fencei | cmt_i_jalr | mispred;
        sel         = tgt_sel(cmt_i_mret, cmt_i_dret, cmt_i_fencei, cmt_i_jalr, cmt_i_rslv);
    end

    e203_exu_bjp_tgt_calc #(
        .XLEN    (XLEN),
        .PC_SIZE (PC_SIZE)
    ) u_tgt_calc (
        .sel      (sel),
        .rv32     (cmt_i_rv32),
        .pc       (cmt_i_pc),
        .rs1      (cmt_i_rs1),
        .imm      (cmt_i_imm),
        .csr_mepc (csr_mepc),
        .csr_dpc  (csr_dpc),
        .tgt      (tgt)
    );

    // Next-state, redirect and counter update logic
    always_comb begin
        state_d       = state_q;
        flush_req_d   = flush_req_q;
        flush_pc_d    = flush_pc_q;
        bjp_cnt_d     = bjp_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && need_flush) begin
                    state_d     = ST_FLUSH;
                    flush_req_d = 1'b1;
                    flush_pc_d  = tgt;
                end
            end
            ST_FLUSH: begin
                // Exception flush wins over ack; either way the request retires
                if (excp_flush || flush_ack) begin
                    state_d     = ST_IDLE;
                    flush_req_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flush_req_d = 1'b0;
            end
        endcase

        if (accept) begin
            bjp_cnt_d     = bjp_cnt_q + CNT_W'(cmt_i_bjp);
            mispred_cnt_d = mispred_cnt_q + CNT_W'(mispred);
        end
    end

    // State, redirect and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            flush_req_q   <= 1'b0;
            flush_pc_q    <= '0;
            bjp_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_req_q   <= flush_req_d;
            flush_pc_q    <= flush_pc_d;
            bjp_cnt_q     <= bjp_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign flush_req   = flush_req_q;
    assign flush_pc    = flush_pc_q;
    assign bjp_cnt     = bjp_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
